// File: rtl/taylor_exp_root_if.sv
// Operand/result handshake bundle for taylor_exp_root.
// master drives operands and accepts results; slave is the exp/root unit.
interface taylor_exp_root_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ln_x;
  logic [31:0] n_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  modport master (output in_valid, ln_x, n_val, out_ready,
                  input  in_ready, out_valid, out);
  modport slave  (input  in_valid, ln_x, n_val, out_ready,
                  output in_ready, out_valid, out);
endinterface

// File: rtl/taylor_exp_root.sv
// taylor_exp_root: final nth-root stage, out = exp(ln_x / n_val) for IEEE-754
// single operands. One Taylor term per clock after a one-cycle scale step.
// Optional macro RANGE_RED_EN: halves |y| into [0.5,1) by exponent
// adjustment and squares the series result k times afterwards.
// chia/nhan/cong_tru are the combinational divide/multiply/add units
// (round-to-nearest-even, denormals flushed to zero).
module taylor_exp_root #(
  parameter int unsigned N_TERMS = 12,
  parameter int unsigned MAX_SQ  = 8
) (
  input logic               clk,
  input logic               rst,
  taylor_exp_root_if.slave  bus
);

  if (N_TERMS < 2 || N_TERMS > 15 || MAX_SQ > 15) begin : g_param_check
    $error("taylor_exp_root: N_TERMS must be 2..15 and MAX_SQ at most 15");
  end

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCALE  = 3'd1;
  localparam logic [2:0] S_SERIES = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef RANGE_RED_EN
  localparam logic [2:0] S_SQUARE = 3'd4;
  localparam logic [7:0] MAX_K    = 8'(MAX_SQ);
`endif

  localparam logic [31:0] ONE    = 32'h3F800000;
  localparam logic [31:0] QNAN   = 32'h7FC00000;
  localparam logic [31:0] PINF   = 32'h7F800000;
  localparam logic [3:0]  LAST_I = 4'(N_TERMS - 1);

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Round a 24-bit significand (leading one at bit 23) and pack.
  function automatic logic [31:0] rnd_pack(input logic sgn, input logic signed [10:0] e,
                                           input logic [23:0] m, input logic g, input logic s);
    logic [24:0]        r;
    logic signed [10:0] ex;
    logic [22:0]        f;
    r  = {1'b0, m} + {24'd0, g & (s | m[0])};
    ex = e;
    f  = r[22:0];
    if (r[24]) begin
      ex = e + 11'sd1;
      f  = r[23:1];
    end
    if (ex >= 11'sd255) return {sgn, 8'hFF, 23'd0};
    if (ex <= 11'sd0)   return {sgn, 31'd0};
    return {sgn, ex[7:0], f};
  endfunction

  function automatic logic [31:0] nhan(input logic [31:0] a, input logic [31:0] b);
    logic               sgn;
    logic [47:0]        p;
    logic signed [10:0] e;
    sgn = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? QNAN : {sgn, 8'hFF, 23'd0};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sgn, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) return rnd_pack(sgn, e + 11'sd1, p[47:24], p[23], |p[22:0]);
    return rnd_pack(sgn, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] chia(input logic [31:0] a, input logic [31:0] b);
    logic               sgn;
    logic [49:0]        num, den, q;
    logic               st;
    logic signed [10:0] e;
    sgn = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (a[30:23] == 8'hFF) return (b[30:23] == 8'hFF) ? QNAN : {sgn, 8'hFF, 23'd0};
    if (b[30:23] == 8'hFF) return {sgn, 31'd0};
    if (b[30:23] == 8'd0)  return (a[30:23] == 8'd0) ? QNAN : {sgn, 8'hFF, 23'd0};
    if (a[30:23] == 8'd0)  return {sgn, 31'd0};
    num = {1'b1, a[22:0], 26'd0};
    den = {26'd0, 1'b1, b[22:0]};
    q   = num / den;
    st  = (num % den) != 50'd0;
    e   = $signed({3'b000, a[30:23]}) - $signed({3'b000, b[30:23]}) + 11'sd127;
    if (q[26]) return rnd_pack(sgn, e, q[26:3], q[2], (|q[1:0]) | st);
    return rnd_pack(sgn, e - 11'sd1, q[25:2], q[1], q[0] | st);
  endfunction

  // Operands are aligned in a 51-bit field wide enough that alignment and
  // cancellation are exact; only the final pack rounds.
  function automatic logic [31:0] cong_tru(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
    logic [31:0]        bb, l, s;
    logic [7:0]         d;
    logic [50:0]        ml, ms, r, nrm;
    logic [5:0]         lead;
    logic signed [10:0] e;
    bb = {b[31] ^ sub, b[30:0]};
    if (is_nan(a) || is_nan(bb)) return QNAN;
    if (a[30:23] == 8'hFF)
      return (bb[30:23] == 8'hFF && a[31] != bb[31]) ? QNAN : a;
    if (bb[30:23] == 8'hFF) return bb;
    if (a[30:23] == 8'd0)  return (bb[30:23] == 8'd0) ? 32'd0 : bb;
    if (bb[30:23] == 8'd0) return a;
    if (a[30:0] >= bb[30:0]) begin
      l = a;  s = bb;
    end else begin
      l = bb; s = a;
    end
    d = l[30:23] - s[30:23];
    if (d > 8'd26) return l;
    ml = {2'b01, l[22:0], 26'd0};
    ms = {2'b01, s[22:0], 26'd0} >> d;
    r  = (l[31] ^ s[31]) ? ml - ms : ml + ms;
    if (r == 51'd0) return 32'd0;
    lead = 6'd0;
    for (int unsigned j = 0; j < 51; j++)
      if (r[j]) lead = 6'(j);
    nrm = r << (6'd50 - lead);
    e   = $signed({3'b000, l[30:23]}) + $signed({5'b00000, lead}) - 11'sd49;
    return rnd_pack(l[31], e, nrm[50:27], nrm[26], |nrm[25:0]);
  endfunction

  function automatic logic [31:0] f_tab(input logic [3:0] idx);
    case (idx)
      4'd2:    return 32'h40000000;
      4'd3:    return 32'h40400000;
      4'd4:    return 32'h40800000;
      4'd5:    return 32'h40A00000;
      4'd6:    return 32'h40C00000;
      4'd7:    return 32'h40E00000;
      4'd8:    return 32'h41000000;
      4'd9:    return 32'h41100000;
      4'd10:   return 32'h41200000;
      4'd11:   return 32'h41300000;
      4'd12:   return 32'h41400000;
      4'd13:   return 32'h41500000;
      4'd14:   return 32'h41600000;
      4'd15:   return 32'h41700000;
      default: return ONE;
    endcase
  endfunction

  logic [2:0]  state;
  logic [31:0] ln_r, n_r, y, term, sum, out_r;
  logic [3:0]  i;
  logic        out_valid_r;
  logic [31:0] y_div, term_nx, sum_nx;
`ifdef RANGE_RED_EN
  logic [3:0]  k;
  logic [31:0] sq;
  logic [7:0]  y_exp, k_nx;
`endif

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;

  // Datapath: scaled exponent argument, next series term and running sum.
  always_comb begin
    y_div   = chia(ln_r, n_r);
    term_nx = chia(nhan(term, y), f_tab(i));
    sum_nx  = cong_tru(sum, term_nx, 1'b0);
`ifdef RANGE_RED_EN
    sq    = nhan(sum, sum);
    y_exp = y_div[30:23];
    k_nx  = y_exp - 8'd126;
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ln_r        <= '0;
      n_r         <= '0;
      y           <= '0;
      term        <= '0;
      sum         <= '0;
      out_r       <= '0;
      i           <= '0;
      out_valid_r <= 1'b0;
`ifdef RANGE_RED_EN
      k           <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            ln_r  <= bus.ln_x;
            n_r   <= bus.n_val;
            state <= S_SCALE;
          end
        end
        S_SCALE: begin
          y    <= y_div;
          term <= ONE;
          sum  <= ONE;
          i    <= 4'd1;
          if (is_nan(ln_r) || is_nan(n_r) || n_r[30:0] == 31'd0) begin
            out_r       <= QNAN;
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end else if (ln_r[30:0] == 31'd0) begin
            out_r       <= ONE;
            out_valid_r <= 1'b1;
            state       <= S_DONE;
`ifdef RANGE_RED_EN
          end else if (y_exp >= 8'd127) begin
            if (k_nx > MAX_K) begin
              out_r       <= y_div[31] ? 32'd0 : PINF;
              out_valid_r <= 1'b1;
              state       <= S_DONE;
            end else begin
              // exponent e-k is always 126, so |y| lands in [0.5,1)
              y     <= {y_div[31], y_exp - k_nx, y_div[22:0]};
              k     <= k_nx[3:0];
              state <= S_SERIES;
            end
`endif
          end else begin
            state <= S_SERIES;
          end
        end
        S_SERIES: begin
          term <= term_nx;
          sum  <= sum_nx;
          i    <= i + 4'd1;
          if (i == LAST_I) begin
            out_r <= sum_nx;
`ifdef RANGE_RED_EN
            if (k != 4'd0) begin
              state <= S_SQUARE;
            end else begin
              out_valid_r <= 1'b1;
              state       <= S_DONE;
            end
`else
            out_valid_r <= 1'b1;
            state       <= S_DONE;
`endif
          end
        end
`ifdef RANGE_RED_EN
        S_SQUARE: begin
          sum <= sq;
          k   <= k - 4'd1;
          if (k == 4'd1) begin
            out_r       <= sq;
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
